prio_encoder_rr: RTL and testbench
==================================

Name: prio_encoder_rr

Overview:
- Parametrised, registered successor to the 8-to-3 one-hot encoder.
- Accepts an N-bit request vector through a valid/ready handshake and emits the binary index of one selected set bit, plus that bit as a one-hot vector and a multi-hot flag.
- Selection is either fixed priority (lowest index wins) or round-robin with a rotating pointer.
- Sits between request sources (interrupt lines, FIFO-not-empty flags) and a downstream consumer that may stall.

Parameters:
- N, 8, number of request bits; power of two, N >= 2.
- MODE, 0, 0 = fixed priority, LSB first; 1 = round-robin.
- W (localparam), $clog2(N), index width; not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_req is valid this cycle.
- in_ready  output  1  block can accept in_req this cycle.
- in_req  input  N  request vector; bit i = request i.
- out_valid  output  1  out_idx, out_onehot and out_multi are valid.
- out_ready  input  1  consumer accepts the output this cycle.
- out_idx  output  W  binary index of the selected request.
- out_onehot  output  N  one-hot of the selected request, equal to 1 << out_idx.
- out_multi  output  1  more than one in_req bit was set for this result.

Behaviour:
- **Reset** (rst_n low, asynchronous): out_valid=0, out_idx=0, out_onehot=0, out_multi=0, rr_ptr=0. in_ready reads 1 once out_valid is 0.
- **Handshake:** in_ready = !out_valid || out_ready, combinational; no other path from out_ready to in_ready.
  - Input accept: in_valid && in_ready on a rising edge.
  - Output transfer: out_valid && out_ready.
- **Latency:** 1 cycle. A request accepted at edge k is presented from edge k onward and is held stable until transferred.
- **Throughput:** one result per cycle when out_ready is held 1.
- **Accept with in_req != 0:** out_valid<=1; out_idx, out_onehot and out_multi load from the selection logic.
- **Accept with in_req == 0:** the request is consumed and produces no output. out_valid<=0 if the previous result transfers that cycle, otherwise it holds. rr_ptr is unchanged.
- **No accept but transfer:** out_valid<=0. The data registers hold their last values; their contents are don't-care while out_valid=0.
- **Stall** (out_valid && !out_ready): all outputs and rr_ptr hold; in_ready=0.
- **Fixed mode (MODE=0):** select the lowest set index. in_req=8'b1010_0100 gives idx 2.
- **Round-robin mode (MODE=1):**
  - Search starts at rr_ptr and goes upward modulo N; the first set bit wins.
  - On each accept with in_req != 0, rr_ptr <= (idx+1) mod N. Wrap from N-1 to 0 is natural W-bit overflow.
- **out_multi:** 1 iff popcount(in_req) >= 2 at acceptance. It is independent of mode and does not affect selection.
- **Single-bit input:** identical result in both modes, and out_multi=0.
- **Reset mid-stall:** the pending output is discarded, out_valid falls immediately, and rr_ptr returns to 0.
- **Implementation:** the selection logic is fully combinational from in_req and rr_ptr. A single output register stage; no skid buffer.

Optional Feature:
- Macro: PRIO_ENC_STAT_EN.
- **When defined**, two extra output ports are added, both cleared by rst_n:
  - stat_multi [15:0]: 16-bit saturating count of accepts with out_multi=1.
  - stat_zero [15:0]: 16-bit saturating count of accepts with in_req=0.
  - Each counter increments by 1 per qualifying accept and holds at 16'hFFFF.
- **When not defined**, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- N=8, MODE=0, out_ready=1, one accept per cycle with in_req=8'h01, 8'h80, 8'h24 -> out_idx=0, 7, 2 on successive cycles; out_onehot=8'h01, 8'h80, 8'h04; out_multi=0, 0, 1.
- N=8, MODE=1, in_req=8'hFF held for 9 accepts -> out_idx sequence 0,1,...,7,0; rr_ptr wraps 7->0; out_multi=1 throughout.
- MODE=1, rr_ptr=5, in_req=8'h09 -> out_idx=0 (wrap search), then rr_ptr=1; next in_req=8'h09 -> out_idx=3.
- Back-pressure: accept in_req=8'h10, then hold out_ready=0 for 3 cycles with in_valid=1 and in_req=8'h02 -> in_ready=0, out_idx stays 4; on out_ready=1, in_req=8'h02 is accepted and out_idx=1 on the next cycle.
- in_req=8'h00 accepted while output empty -> out_valid stays 0, rr_ptr unchanged; with PRIO_ENC_STAT_EN, stat_zero increments to 1.
- Assert rst_n=0 asynchronously while stalled with out_valid=1 -> out_valid=0 and out_idx=0 before the next clk edge; after release, MODE=1 with in_req=8'hFF gives out_idx=0.

Source files
------------

// File: rtl/prio_encoder_rr.sv
// Registered priority / round-robin encoder with valid/ready handshake.
// Ports: clk, rst_n (async low), in_valid/in_ready/in_req (N-bit request),
//   out_valid/out_ready, out_idx (W-bit index), out_onehot, out_multi.
//   With PRIO_ENC_STAT_EN: stat_multi, stat_zero (16-bit saturating).
// Params: N (power of two, >= 2), MODE (0 fixed LSB-first, 1 round-robin).
module prio_encoder_rr #(
   parameter int N    = 8,
   parameter int MODE = 0,
   localparam int W   = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_req,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] out_onehot,
   output logic         out_multi
`ifdef PRIO_ENC_STAT_EN
   ,
   output logic [15:0]  stat_multi,
   output logic [15:0]  stat_zero
`endif
);

   localparam logic [W-1:0] ONE_W = 1;
   localparam logic [N-1:0] ONE_N = 1;

   logic         valid_q, valid_d;
   logic [W-1:0] idx_q, idx_d;
   logic [N-1:0] oh_q, oh_d;
   logic         multi_q, multi_d;
   logic [W-1:0] ptr_q, ptr_d;

   logic         accept;
   logic         nonzero;
   logic         found;
   logic [W-1:0] start;
   logic [W-1:0] cand;
   logic [W-1:0] sel_idx;
   logic         multi_hot;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign nonzero  = |in_req;

   // Clearing the lowest set bit leaves something only if >= 2 bits set.
   assign multi_hot = (in_req & (in_req - ONE_N)) != '0;

   // Fixed mode is round-robin with the search origin pinned at 0.
   assign start = (MODE == 1) ? ptr_q : '0;

   always_comb begin
      found   = 1'b0;
      sel_idx = '0;
      cand    = '0;
      for (int i = 0; i < N; i++) begin
         // W-bit add wraps the search modulo N.
         cand = start + i[W-1:0];
         if (!found && in_req[cand]) begin
            found   = 1'b1;
            sel_idx = cand;
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      idx_d   = idx_q;
      oh_d    = oh_q;
      multi_d = multi_q;
      ptr_d   = ptr_q;
      if (accept && nonzero) begin
         valid_d = 1'b1;
         idx_d   = sel_idx;
         oh_d    = ONE_N << sel_idx;
         multi_d = multi_hot;
         ptr_d   = sel_idx + ONE_W;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         idx_q   <= '0;
         oh_q    <= '0;
         multi_q <= 1'b0;
         ptr_q   <= '0;
      end else begin
         valid_q <= valid_d;
         idx_q   <= idx_d;
         oh_q    <= oh_d;
         multi_q <= multi_d;
         ptr_q   <= ptr_d;
      end
   end

   assign out_valid  = valid_q;
   assign out_idx    = idx_q;
   assign out_onehot = oh_q;
   assign out_multi  = multi_q;

`ifdef PRIO_ENC_STAT_EN
   logic [15:0] smulti_q, smulti_d;
   logic [15:0] szero_q, szero_d;

   always_comb begin
      smulti_d = smulti_q;
      szero_d  = szero_q;
      if (accept && nonzero && multi_hot && smulti_q != 16'hFFFF)
         smulti_d = smulti_q + 16'd1;
      if (accept && !nonzero && szero_q != 16'hFFFF)
         szero_d = szero_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         smulti_q <= '0;
         szero_q  <= '0;
      end else begin
         smulti_q <= smulti_d;
         szero_q  <= szero_d;
      end
   end

   assign stat_multi = smulti_q;
   assign stat_zero  = szero_q;
`endif

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: one fixed and one round-robin instance,
// table vectors plus hand-written stall / zero / reset sequences.
module tb_prio_encoder_rr;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       iv0 = 1'b0, ir0, ov0, ordy0 = 1'b1, om0;
   logic [7:0] rq0 = '0, oh0;
   logic [2:0] oi0;
   logic       iv1 = 1'b0, ir1, ov1, ordy1 = 1'b1, om1;
   logic [7:0] rq1 = '0, oh1;
   logic [2:0] oi1;
`ifdef PRIO_ENC_STAT_EN
   logic [15:0] sm0, sz0, sm1, sz1;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] idx;
      logic       m;
   } exp_t;

   typedef struct {
      bit         d;
      logic [7:0] req;
      logic [2:0] idx;
      logic       m;
   } vec_t;

   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   prio_encoder_rr #(.N(8), .MODE(0)) u0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv0), .in_ready(ir0), .in_req(rq0),
      .out_valid(ov0), .out_ready(ordy0),
      .out_idx(oi0), .out_onehot(oh0), .out_multi(om0)
`ifdef PRIO_ENC_STAT_EN
      , .stat_multi(sm0), .stat_zero(sz0)
`endif
   );

   prio_encoder_rr #(.N(8), .MODE(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv1), .in_ready(ir1), .in_req(rq1),
      .out_valid(ov1), .out_ready(ordy1),
      .out_idx(oi1), .out_onehot(oh1), .out_multi(om1)
`ifdef PRIO_ENC_STAT_EN
      , .stat_multi(sm1), .stat_zero(sz1)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard: compare every output transfer against the queue head.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && ov0 && ordy0) begin
         if (q0.size() == 0) begin
            chk("u0_unexpected_out", 32'd1, 32'd0);
         end else begin
            e = q0.pop_front();
            chk("u0_idx", {29'd0, oi0}, {29'd0, e.idx});
            chk("u0_onehot", {24'd0, oh0}, {24'd0, 8'd1 << e.idx});
            chk("u0_multi", {31'd0, om0}, {31'd0, e.m});
         end
      end
      if (rst_n && ov1 && ordy1) begin
         if (q1.size() == 0) begin
            chk("u1_unexpected_out", 32'd1, 32'd0);
         end else begin
            e = q1.pop_front();
            chk("u1_idx", {29'd0, oi1}, {29'd0, e.idx});
            chk("u1_onehot", {24'd0, oh1}, {24'd0, 8'd1 << e.idx});
            chk("u1_multi", {31'd0, om1}, {31'd0, e.m});
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input bit d, input logic [7:0] req,
                       input logic [2:0] idx, input logic m);
      bit   ok = 1'b0;
      exp_t e;
      e.idx = idx;
      e.m   = m;
      if (d) begin iv1 = 1'b1; rq1 = req; end
      else   begin iv0 = 1'b1; rq0 = req; end
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (d ? ir1 : ir0) begin
            ok = 1'b1;
            if (req != 8'h00) begin
               if (d) q1.push_back(e);
               else   q0.push_back(e);
            end
         end
         @(posedge clk);
         #1;
      end
      if (!ok) chk("send_timeout", 32'd1, 32'd0);
   endtask

   task automatic idle(input int n);
      iv0 = 1'b0;
      iv1 = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   vec_t tbl[$];

   initial begin
      tbl = '{
         '{0, 8'h01, 3'd0, 1'b0}, '{0, 8'h80, 3'd7, 1'b0},
         '{0, 8'h24, 3'd2, 1'b1}, '{0, 8'hA4, 3'd2, 1'b1},
         '{0, 8'h00, 3'd0, 1'b0}, '{0, 8'h03, 3'd0, 1'b1},
         '{0, 8'h40, 3'd6, 1'b0},
         '{1, 8'hFF, 3'd0, 1'b1}, '{1, 8'hFF, 3'd1, 1'b1},
         '{1, 8'hFF, 3'd2, 1'b1}, '{1, 8'hFF, 3'd3, 1'b1},
         '{1, 8'hFF, 3'd4, 1'b1}, '{1, 8'hFF, 3'd5, 1'b1},
         '{1, 8'hFF, 3'd6, 1'b1}, '{1, 8'hFF, 3'd7, 1'b1},
         '{1, 8'hFF, 3'd0, 1'b1},
         '{1, 8'h10, 3'd4, 1'b0},
         '{1, 8'h09, 3'd0, 1'b1}, '{1, 8'h09, 3'd3, 1'b1},
         '{1, 8'h40, 3'd6, 1'b0}
      };

      #2;
      chk("rst_valid", {31'd0, ov0}, 32'd0);
      chk("rst_idx", {29'd0, oi0}, 32'd0);
      chk("rst_onehot", {24'd0, oh0}, 32'd0);
      chk("rst_multi", {31'd0, om0}, 32'd0);
      chk("rst_in_ready", {31'd0, ir0}, 32'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         if (tbl[i].d) iv0 = 1'b0;
         else          iv1 = 1'b0;
         send(tbl[i].d, tbl[i].req, tbl[i].idx, tbl[i].m);
      end
      idle(3);

      // Zero request while empty: no output, pointer stays at 7.
      send(1, 8'h00, 3'd0, 1'b0);
      iv1 = 1'b0;
      @(negedge clk);
      chk("zero_no_valid", {31'd0, ov1}, 32'd0);
`ifdef PRIO_ENC_STAT_EN
      chk("stat_zero", {16'd0, sz1}, 32'd1);
      chk("stat_multi", {16'd0, sm1}, 32'd11);
`endif
      @(posedge clk);
      #1;
      send(1, 8'h81, 3'd7, 1'b1);
      idle(3);

      // Back-pressure on the fixed instance.
      send(0, 8'h10, 3'd4, 1'b0);
      ordy0 = 1'b0;
      rq0   = 8'h02;
      repeat (3) begin
         @(negedge clk);
         chk("stall_in_ready", {31'd0, ir0}, 32'd0);
         chk("stall_valid", {31'd0, ov0}, 32'd1);
         chk("stall_idx", {29'd0, oi0}, 32'd4);
         @(posedge clk);
         #1;
      end
      ordy0 = 1'b1;
      send(0, 8'h02, 3'd1, 1'b0);
      idle(3);

      // Async reset while the round-robin instance is stalled.
      ordy1 = 1'b0;
      iv1   = 1'b1;
      rq1   = 8'h08;
      @(posedge clk);
      #1 iv1 = 1'b0;
      @(posedge clk);
      #1;
      chk("pre_rst_valid", {31'd0, ov1}, 32'd1);
      chk("pre_rst_idx", {29'd0, oi1}, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, ov1}, 32'd0);
      chk("mid_rst_idx", {29'd0, oi1}, 32'd0);
      chk("mid_rst_onehot", {24'd0, oh1}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      ordy1 = 1'b1;
      @(posedge clk);
      #1;
      send(1, 8'hFF, 3'd0, 1'b1);
      idle(3);

      chk("q0_drained", q0.size(), 32'd0);
      chk("q1_drained", q1.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
